// File: rtl/onehot_drain_encoder.sv
// rtl/onehot_drain_encoder.sv - registered one-hot / multi-hot request encoder with SINGLE and DRAIN modes
module onehot_drain_encoder #(
  parameter int WIDTH = 8,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] code_out,
  output logic            out_last,
  output logic            multi_err,
  output logic            zero_err
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] pend;
  logic             mode_q;
  logic [WIDTH-1:0] pend_next;

  function automatic logic [IDXW-1:0] lowest_idx(input logic [WIDTH-1:0] v);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) idx = IDXW'(i);
    end
    return idx;
  endfunction

  // True for zero or exactly one bit set.
  function automatic logic at_most_one(input logic [WIDTH-1:0] v);
    return (v & (v - ONE)) == '0;
  endfunction

  assign pend_next = pend & (pend - ONE);
  assign in_ready  = (state == IDLE);

  // Outputs for the next beat are computed one edge ahead so every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend      <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      code_out  <= '0;
      out_last  <= 1'b0;
      multi_err <= 1'b0;
      zero_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pend      <= data_in;
            mode_q    <= mode;
            multi_err <= !at_most_one(data_in);
            zero_err  <= (data_in == '0);
            code_out  <= lowest_idx(data_in);
            out_last  <= !mode || at_most_one(data_in);
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              pend      <= '0;
              out_valid <= 1'b0;
              code_out  <= '0;
              out_last  <= 1'b0;
              multi_err <= 1'b0;
              zero_err  <= 1'b0;
              state     <= IDLE;
            end else begin
              pend     <= pend_next;
              code_out <= lowest_idx(pend_next);
              out_last <= !mode_q || at_most_one(pend_next);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_drain_encoder.sv
// tb/tb_onehot_drain_encoder.sv - scoreboard bench for onehot_drain_encoder at WIDTH=8 and WIDTH=5
module tb_onehot_drain_encoder;

  typedef struct packed {
    logic [2:0] code;
    logic       last;
    logic       multi;
    logic       zero;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       mode8 = 1'b0, in_valid8 = 1'b0, out_ready8 = 1'b1;
  logic [7:0] data_in8 = '0;
  logic       in_ready8, out_valid8, out_last8, multi_err8, zero_err8;
  logic [2:0] code_out8;

  logic       mode5 = 1'b0, in_valid5 = 1'b0, out_ready5 = 1'b1;
  logic [4:0] data_in5 = '0;
  logic       in_ready5, out_valid5, out_last5, multi_err5, zero_err5;
  logic [2:0] code_out5;

  int checks = 0;
  int errors = 0;
  beat_t q8[$];
  beat_t q5[$];

  always #5 clk = ~clk;

  onehot_drain_encoder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .mode(mode8), .in_valid(in_valid8), .in_ready(in_ready8),
    .data_in(data_in8), .out_valid(out_valid8), .out_ready(out_ready8), .code_out(code_out8),
    .out_last(out_last8), .multi_err(multi_err8), .zero_err(zero_err8)
  );

  onehot_drain_encoder #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .in_valid(in_valid5), .in_ready(in_ready5),
    .data_in(data_in5), .out_valid(out_valid5), .out_ready(out_ready5), .code_out(code_out5),
    .out_last(out_last5), .multi_err(multi_err5), .zero_err(zero_err5)
  );

  // Reference model: expected beats for one captured vector.
  task automatic push_expect(input logic [7:0] v, input int w, input logic m, input bit to5);
    beat_t b;
    int    ones;
    int    emitted;
    ones = 0;
    for (int i = 0; i < w; i++) if (v[i]) ones++;
    if (ones == 0) begin
      b = '{code: 3'd0, last: 1'b1, multi: 1'b0, zero: 1'b1};
      if (to5) q5.push_back(b); else q8.push_back(b);
      return;
    end
    emitted = 0;
    for (int i = 0; i < w; i++) begin
      if (v[i] && (m || emitted == 0)) begin
        emitted++;
        b.code  = 3'(i);
        b.last  = !m || (emitted == ones);
        b.multi = (ones >= 2);
        b.zero  = 1'b0;
        if (to5) q5.push_back(b); else q8.push_back(b);
      end
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst_n && out_valid8 && out_ready8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL beat8_unexpected: got code=%0d last=%0b, expected no beat", code_out8, out_last8);
      end else begin
        e = q8.pop_front();
        if ({code_out8, out_last8, multi_err8, zero_err8} !== e) begin
          errors++;
          $display("FAIL beat8: got code=%0d last=%0b multi=%0b zero=%0b, expected code=%0d last=%0b multi=%0b zero=%0b",
                   code_out8, out_last8, multi_err8, zero_err8, e.code, e.last, e.multi, e.zero);
        end
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (rst_n && out_valid5 && out_ready5) begin
      checks++;
      if (q5.size() == 0) begin
        errors++;
        $display("FAIL beat5_unexpected: got code=%0d, expected no beat", code_out5);
      end else begin
        e = q5.pop_front();
        if ({code_out5, out_last5, multi_err5, zero_err5} !== e || code_out5 >= 3'd5) begin
          errors++;
          $display("FAIL beat5: got code=%0d last=%0b multi=%0b zero=%0b, expected code=%0d last=%0b multi=%0b zero=%0b",
                   code_out5, out_last5, multi_err5, zero_err5, e.code, e.last, e.multi, e.zero);
        end
      end
    end
  end

  // Callers sit at posedge+1; returns at posedge+1 just after the capture edge.
  task automatic send8(input logic [7:0] v, input logic m);
    int n = 0;
    while (!in_ready8 && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready8) begin
      checks++; errors++;
      $display("FAIL send8_timeout: in_ready=%0b, expected 1", in_ready8);
    end
    push_expect(v, 8, m, 1'b0);
    data_in8 = v; mode8 = m; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0; data_in8 = 8'($urandom); mode8 = 1'($urandom);
  endtask

  task automatic send5(input logic [4:0] v, input logic m);
    int n = 0;
    while (!in_ready5 && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready5) begin
      checks++; errors++;
      $display("FAIL send5_timeout: in_ready=%0b, expected 1", in_ready5);
    end
    push_expect({3'b000, v}, 5, m, 1'b1);
    data_in5 = v; mode5 = m; in_valid5 = 1'b1;
    @(posedge clk); #1;
    in_valid5 = 1'b0; data_in5 = 5'($urandom); mode5 = 1'($urandom);
  endtask

  task automatic wait_done8();
    int n = 0;
    while ((q8.size() != 0 || !in_ready8) && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (q8.size() != 0 || !in_ready8) begin
      errors++;
      $display("FAIL drain8_timeout: pending=%0d in_ready=%0b, expected 0 and 1", q8.size(), in_ready8);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready8, out_valid8, code_out8, out_last8, multi_err8, zero_err8} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset8: got rdy=%0b vld=%0b code=%0d last=%0b m=%0b z=%0b, expected 1 0 0 0 0 0",
               in_ready8, out_valid8, code_out8, out_last8, multi_err8, zero_err8);
    end
    checks++;
    if ({in_ready5, out_valid5, code_out5, out_last5, multi_err5, zero_err5} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset5: got rdy=%0b vld=%0b code=%0d, expected 1 0 0", in_ready5, out_valid5, code_out5);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_onehot_sweep();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 8'h01 << i;
      send8(v, 1'b0);
      checks++;
      if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0) begin
        errors++;
        $display("FAIL sweep_latency[%0d]: got vld=%0b rdy=%0b, expected 1 0", i, out_valid8, in_ready8);
      end
    end
    wait_done8();
  endtask

  task automatic test_drain_multi();
    int c = 0;
    send8(8'b1010_0110, 1'b1);
    while (!in_ready8 && c < 20) begin @(posedge clk); #1; c++; end
    checks++;
    if (c != 4) begin
      errors++;
      $display("FAIL drain_cycles: got %0d cycles to in_ready, expected 4", c);
    end
    wait_done8();
  endtask

  task automatic test_single_multi_zero();
    send8(8'b1010_0110, 1'b0);
    send8(8'h00, 1'b1);
    wait_done8();
  endtask

  task automatic test_backpressure();
    out_ready8 = 1'b0;
    send8(8'b0001_1000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid8 !== 1'b1 || code_out8 !== 3'd3 || out_last8 !== 1'b0 || multi_err8 !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got vld=%0b code=%0d last=%0b multi=%0b, expected 1 3 0 1",
                 k, out_valid8, code_out8, out_last8, multi_err8);
      end
      in_valid8 = 1'b1; data_in8 = 8'($urandom); mode8 = ~mode8;
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    wait_done8();
  endtask

  task automatic test_reset_mid();
    send8(8'hFF, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (q8.size() != 6) begin
      errors++;
      $display("FAIL mid_beats: got %0d pending, expected 6", q8.size());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || code_out8 !== 3'd0 || multi_err8 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got vld=%0b rdy=%0b code=%0d multi=%0b, expected 0 1 0 0",
               out_valid8, in_ready8, code_out8, multi_err8);
    end
    q8.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid8 !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet[%0d]: got vld=%0b, expected 0", k, out_valid8);
      end
    end
    send8(8'h40, 1'b0);
    wait_done8();
  endtask

  task automatic test_width5();
    int n = 0;
    send5(5'b10001, 1'b1);
    while ((q5.size() != 0 || !in_ready5) && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (q5.size() != 0 || !in_ready5) begin
      errors++;
      $display("FAIL drain5_timeout: pending=%0d in_ready=%0b, expected 0 and 1", q5.size(), in_ready5);
    end
  endtask

  initial begin
    test_reset();
    test_onehot_sweep();
    test_drain_multi();
    test_single_multi_zero();
    test_backpressure();
    test_reset_mid();
    test_width5();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_drain_encoder.md
# onehot_drain_encoder

Parametrised, registered successor to the fixed 8-to-3 one-hot encoder. Captures a WIDTH-bit request vector through a valid/ready handshake and emits bit indices through a second valid/ready handshake. In SINGLE mode it emits only the lowest set bit; in DRAIN mode it emits every set bit in ascending order, one per beat. It sits between request-producing logic (buttons, interrupt lines, FIFO flags) and any consumer that needs binary indices. It also reports vectors that are not one-hot.

## Interface
- WIDTH, default 8: request vector width; legal range 2..64.
- IDXW, default $clog2(WIDTH) (derived, not overridden): index width; 3 for WIDTH=8.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = SINGLE, 1 = DRAIN; sampled only at capture.
- in_valid  in  1  data_in valid.
- in_ready  out  1  block can capture a vector.
- data_in  in  WIDTH  request vector; bit i maps to index i.
- out_valid  out  1  code_out/flags valid.
- out_ready  in  1  consumer accepts the current beat.
- code_out  out  IDXW  index of the emitted set bit.
- out_last  out  1  final beat for the captured vector.
- multi_err  out  1  captured vector had ≥2 bits set.
- zero_err  out  1  captured vector had no bits set.

## Operation
- States: IDLE and EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: register data_in into pend, mode into mode_q, and the flags multi_err=(popcount≥2) and zero_err=(pend==0). Go to EMIT.
- EMIT:
  - in_ready=0, out_valid=1.
  - code_out = index of the lowest set bit of pend; 0 if pend==0.
  - out_last=1 when any of these holds: mode_q==SINGLE; pend has ≤1 bit set; pend==0.
  - On out_valid&out_ready:
    - If out_last: clear pend and return to IDLE.
    - Otherwise: clear the lowest set bit of pend and stay in EMIT.
- Flags: multi_err and zero_err are constant for every beat of one vector and valid only while out_valid=1. They are driven 0 in IDLE.
- Zero vector: produces exactly one beat with code_out=0, zero_err=1, out_last=1. This keeps the legacy default-0 behaviour, now flagged.
- Bits of data_in at index ≥WIDTH do not exist. The index arithmetic is IDXW wide; WIDTH that is not a power of two never produces an index ≥WIDTH.
- Output stall: while out_valid=1 and out_ready=0, code_out, out_last and the flags hold stable. pend does not change.
- Input is ignored while in_ready=0. data_in changes during EMIT have no effect.
- mode changes after capture have no effect until the next capture.

## Timing
- Reset (rst_n=0, asynchronous) forces these values immediately:
  - state=IDLE, pend=0, mode_q=0.
  - in_ready=1 (combinational from state).
  - out_valid=0, code_out=0, out_last=0, multi_err=0, zero_err=0.
- Reset mid-EMIT discards the pending vector; no further beats are emitted.
- Release of rst_n is synchronised externally; the block needs no extra latency.
- Capture-to-first-beat latency: 1 cycle. Capture at edge N gives out_valid=1 after edge N.
- Beats: one per cycle while out_ready=1. A vector with k set bits in DRAIN mode occupies k cycles of EMIT.
- Return from EMIT to IDLE: in_ready=1 in the cycle after the last beat is accepted. There is no same-cycle bypass.
  - Throughput: one vector per k+1 cycles in DRAIN mode.
  - Throughput: one vector per 2 cycles in SINGLE mode.
- All outputs are registered or decoded from registered state only. There is no combinational path from data_in, in_valid or out_ready to any output.

## Test plan
- Reset and one-hot sweep:
  - Stimulus: WIDTH=8, SINGLE mode; apply each of 8'h01..8'h80 with out_ready=1.
  - Required response: code_out 0..7, each with out_last=1, multi_err=0, zero_err=0; first beat exactly 1 cycle after capture.
- DRAIN multi-hot:
  - Stimulus: data_in=8'b1010_0110, mode=1, out_ready=1.
  - Required response: 4 beats with code_out 1,2,5,7; out_last only on the 7; multi_err=1 on all 4 beats; in_ready returns 1 cycle after the final beat.
- SINGLE multi-hot and zero:
  - Stimulus: 8'b1010_0110 with mode=0, then 8'h00.
  - Required response: for the first vector, a single beat with code_out=1, out_last=1, multi_err=1. For the zero vector, a single beat with code_out=0, zero_err=1, out_last=1.
- Backpressure:
  - Stimulus: DRAIN 8'b0001_1000 with out_ready low for 3 cycles, then high.
  - Required response: code_out=3 held stable for 3 cycles; then beats 3, 4 in order; input changes during EMIT are ignored.
- Reset mid-operation:
  - Stimulus: DRAIN 8'hFF; assert rst_n=0 after 2 beats.
  - Required response: out_valid drops immediately; no further beats after reset release; the next vector 8'h40 yields code_out=6.
- Parametrisation:
  - Stimulus: WIDTH=5 (IDXW=3), DRAIN data_in=5'b10001.
  - Required response: beats 0, 4; out_last on the 4; no index ≥5 ever appears.
